// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, register index, opcode/funct encodings,
// field boundaries and the decoded instruction record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0A,
    SLTIU = 6'h0B,
    ANDI  = 6'h0C,
    ORI   = 6'h0D,
    XORI  = 6'h0E,
    LUI   = 6'h0F,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2A,
    SLTU = 6'h2B
  } funct_t;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_LUI
  } imm_ext_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int ADDR_HI  = 25;
  localparam int ADDR_LO  = 0;

  typedef struct packed {
    opcode_t     opcode;
    funct_t      funct;
    regbits_t    rs;
    regbits_t    rt;
    regbits_t    rd;
    logic [4:0]  shamt;
    word_t       imm_ext;
    logic [25:0] addr;
    logic        rtype;
  } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational field decoder: splits an instruction word into its fields and
// builds the extended immediate. Shared with later pipeline stages.
module decode_fields
  import cpu_types_pkg::*;
(
  input  word_t    instr_i,
  output decoded_t dec_o
);

  opcode_t     opcode;
  imm_ext_t    ext_mode;
  logic [15:0] imm;

  assign opcode = opcode_t'(instr_i[OP_HI:OP_LO]);
  assign imm    = instr_i[IMM_HI:IMM_LO];

  // Select how the 16-bit immediate is widened, then assemble the record.
  always_comb begin
    ext_mode = EXT_SIGN;
    case (opcode)
      ANDI, ORI, XORI: ext_mode = EXT_ZERO;
      LUI:             ext_mode = EXT_LUI;
      default:         ext_mode = EXT_SIGN;
    endcase

    dec_o        = '0;
    dec_o.opcode = opcode;
    dec_o.funct  = funct_t'(instr_i[FUNCT_HI:FUNCT_LO]);
    dec_o.rs     = instr_i[RS_HI:RS_LO];
    dec_o.rt     = instr_i[RT_HI:RT_LO];
    dec_o.rd     = instr_i[RD_HI:RD_LO];
    dec_o.shamt  = instr_i[SHAMT_HI:SHAMT_LO];
    dec_o.addr   = instr_i[ADDR_HI:ADDR_LO];
    dec_o.rtype  = (opcode == RTYPE);
    case (ext_mode)
      EXT_ZERO: dec_o.imm_ext = {16'h0000, imm};
      EXT_LUI:  dec_o.imm_ext = {imm, 16'h0000};
      default:  dec_o.imm_ext = {{16{imm[15]}}, imm};
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes each accepted instruction and buffers the
// record with its PC in a DEPTH-entry FIFO; flush drops everything in flight.
module decode_queue
  import cpu_types_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [5:0]       out_funct,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [31:0]      out_imm_ext,
  output logic [25:0]      out_addr,
  output logic             out_rtype,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  decoded_t         in_dec;
  decoded_t         head_ent;
  decoded_t         ent_q [DEPTH];
  logic [PC_W-1:0]  pc_q  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  decode_fields u_decode_fields (
    .instr_i (in_instr),
    .dec_o   (in_dec)
  );

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next pointer/occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage: cleared on reset so outputs read zero, written on push.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (push) begin
      ent_q[tail_q] <= in_dec;
      pc_q[tail_q]  <= in_pc;
    end
  end

  assign head_ent    = ent_q[head_q];
  assign out_opcode  = head_ent.opcode;
  assign out_funct   = head_ent.funct;
  assign out_rs      = head_ent.rs;
  assign out_rt      = head_ent.rt;
  assign out_rd      = head_ent.rd;
  assign out_shamt   = head_ent.shamt;
  assign out_imm_ext = head_ent.imm_ext;
  assign out_addr    = head_ent.addr;
  assign out_rtype   = head_ent.rtype;
  assign out_pc      = pc_q[head_q];
  assign count       = cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed stimulus plus a scoreboard of expected
// decoded records built from a reference decoder.
module tb_decode_queue;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_opcode;
  logic [5:0]       out_funct;
  logic [4:0]       out_rs, out_rt, out_rd, out_shamt;
  logic [31:0]      out_imm_ext;
  logic [25:0]      out_addr;
  logic             out_rtype;
  logic [PC_W-1:0]  out_pc;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sh;
    logic [31:0]     imm;
    logic [25:0]     addr;
    logic            rtype;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   mcnt    = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_funct   (out_funct),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_imm_ext (out_imm_ext),
    .out_addr    (out_addr),
    .out_rtype   (out_rtype),
    .out_pc      (out_pc),
    .count       (count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [PC_W-1:0] pc);
    exp_t e;
    e.op    = w[31:26];
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.rd    = w[15:11];
    e.sh    = w[10:6];
    e.fn    = w[5:0];
    e.addr  = w[25:0];
    e.rtype = (w[31:26] == 6'h00);
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: e.imm = {16'h0000, w[15:0]};
      6'h0F:               e.imm = {w[15:0], 16'h0000};
      default:             e.imm = {{16{w[15]}}, w[15:0]};
    endcase
    e.pc = pc;
    return e;
  endfunction

  // Scoreboard: on each falling edge, predict the coming edge's handshakes.
  always @(negedge CLK) begin
    exp_t h;
    bit   do_push, do_pop;
    if (!nRST) begin
      sb.delete();
      mcnt = 0;
    end else begin
      check_eq("in_ready", in_ready, mcnt != DEPTH);
      check_eq("out_valid", out_valid, mcnt != 0);
      check_eq("count", count, mcnt);
      do_push = in_valid && (mcnt != DEPTH) && !flush;
      do_pop  = (mcnt != 0) && out_ready && !flush;
      if (flush) begin
        sb.delete();
        mcnt = 0;
      end else begin
        if (do_pop) begin
          h = sb.pop_front();
          check_eq("sb_opcode", out_opcode, h.op);
          check_eq("sb_funct", out_funct, h.fn);
          check_eq("sb_rs", out_rs, h.rs);
          check_eq("sb_rt", out_rt, h.rt);
          check_eq("sb_rd", out_rd, h.rd);
          check_eq("sb_shamt", out_shamt, h.sh);
          check_eq("sb_imm_ext", out_imm_ext, h.imm);
          check_eq("sb_addr", out_addr, h.addr);
          check_eq("sb_rtype", out_rtype, h.rtype);
          check_eq("sb_pc", out_pc, h.pc);
        end
        if (do_push) sb.push_back(ref_decode(in_instr, in_pc));
        mcnt = mcnt + int'(do_push) - int'(do_pop);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_count", count, 0);
    check_eq("rst_imm_ext", out_imm_ext, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    nRST = 1'b1;
    step();

    // Single ADDI push: visible after one edge.
    in_valid = 1'b1; in_instr = 32'h2009FFFF; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check_eq("addi_valid", out_valid, 1'b1);
    check_eq("addi_opcode", out_opcode, 6'h08);
    check_eq("addi_rt", out_rt, 5'd9);
    check_eq("addi_imm", out_imm_ext, 32'hFFFFFFFF);
    check_eq("addi_pc", out_pc, 32'h100);
    check_eq("addi_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("addi_drained", count, 0);

    // ORI then LUI: zero-extend and upper-immediate, in order.
    in_valid = 1'b1; in_instr = 32'h3409FFFF; in_pc = 32'h104;
    step();
    in_instr = 32'h3C091234; in_pc = 32'h108;
    step();
    in_valid = 1'b0;
    check_eq("ori_imm", out_imm_ext, 32'h0000FFFF);
    check_eq("ori_pc", out_pc, 32'h104);
    out_ready = 1'b1;
    step();
    check_eq("lui_imm", out_imm_ext, 32'h12340000);
    check_eq("lui_opcode", out_opcode, 6'h0F);
    step();
    out_ready = 1'b0;
    check_eq("lui_drained", count, 0);

    // Fill with out_ready low: third instruction held upstream.
    in_valid = 1'b1; in_instr = 32'h8D280004; in_pc = 32'h200;
    step();
    in_instr = 32'hAD280008; in_pc = 32'h204;
    step();
    check_eq("full_in_ready", in_ready, 1'b0);
    check_eq("full_count", count, 2);
    in_instr = 32'h2128FFF0; in_pc = 32'h208;
    step();
    check_eq("full_hold_count", count, 2);
    check_eq("full_head_pc", out_pc, 32'h200);
    check_eq("full_head_op", out_opcode, 6'h23);
    out_ready = 1'b1;
    step();
    check_eq("full_pop_no_push", count, 1);
    step();
    check_eq("refill_count", count, 1);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_eq("fill_drained", count, 0);

    // Streaming R-types: one per cycle, occupancy stays at 1.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = {6'h00, 5'(i + 1), 5'(i + 10), 5'd8, 5'(i), 6'h20};
      in_pc    = 32'h300 + 32'(i * 4);
      step();
      check_eq("stream_count", count, 1);
      check_eq("stream_rtype", out_rtype, 1'b1);
      check_eq("stream_rd", out_rd, 5'd8);
      check_eq("stream_funct", out_funct, 6'h20);
      check_eq("stream_pc", out_pc, 32'h300 + 32'(i * 4));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_eq("stream_drained", count, 0);

    // Flush with count=2 alongside in_valid and out_ready.
    in_valid = 1'b1; in_instr = 32'h2009000A; in_pc = 32'h400;
    step();
    in_instr = 32'h2009000B; in_pc = 32'h404;
    step();
    check_eq("preflush_count", count, 2);
    in_instr = 32'hDEADBEEF; in_pc = 32'h408;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", out_valid, 1'b0);
    step();
    check_eq("flush_stays_empty", out_valid, 1'b0);

    // Flush with count=1: the push that would otherwise land is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2009000C; in_pc = 32'h500;
    step();
    in_instr = 32'h2009000D; in_pc = 32'h504;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush1_count", count, 0);
    check_eq("flush1_valid", out_valid, 1'b0);
    step();
    check_eq("flush1_empty", count, 0);
    out_ready = 1'b0;

    // Async reset mid-stream with one entry held.
    in_valid = 1'b1; in_instr = 32'h2009FFFF; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    check_eq("prerst_count", count, 1);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    check_eq("arst_count", count, 0);
    check_eq("arst_imm", out_imm_ext, 32'h0);
    check_eq("arst_pc", out_pc, 32'h0);
    check_eq("arst_rt", out_rt, 5'd0);
    #3;
    nRST = 1'b1;
    step();
    check_eq("postrst_imm", out_imm_ext, 32'h0);
    check_eq("postrst_opcode", out_opcode, 6'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational field decoder: a registered, buffered decode stage between fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake, and decodes each one on acceptance.
- Decoding covers all fields plus the extended immediate (sign, zero, or LUI mode) and an R-type flag.
- Each decoded record is held in a DEPTH-entry FIFO and presented downstream on a second valid/ready handshake; a synchronous flush drops all in-flight entries on branch redirect.

Parameters:
- DEPTH, 2, number of buffered decoded entries; power of two, at least 2.
- PC_W, 32, width of the PC carried alongside each instruction.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous reset, active low.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_instr  input  32  raw instruction word (word_t).
- in_pc  input  PC_W  PC of in_instr.
- flush  input  1  drop all entries; synchronous.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- out_opcode  output  6  opcode_t of head.
- out_funct  output  6  funct_t of head.
- out_rs, out_rt, out_rd  output  5 each  register fields (regbits_t).
- out_shamt  output  5  shift amount.
- out_imm_ext  output  32  extended immediate.
- out_addr  output  26  jump target field.
- out_rtype  output  1  opcode == RTYPE.
- out_pc  output  PC_W  PC of head.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (nRST low, asynchronous):
  - head pointer, tail pointer and count go to 0; out_valid = 0; in_ready = 1.
  - All entry storage is cleared, so every out_* field reads 0.
- Push when in_valid && in_ready && !flush:
  - The decoded record is written to the tail slot at the clock edge.
  - The decode is combinational on in_instr and is not re-evaluated later.
- Pop when out_valid && out_ready && !flush: the head advances at the clock edge.
- in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). Output fields are driven directly from the head slot, with no output mux delay stage.
- Latency: an instruction accepted at edge N is visible with out_valid = 1 after edge N. This gives a one-cycle minimum through-latency and full throughput of one instruction per cycle when DEPTH ≥ 2.
- Count update:
  - push and pop together: count unchanged, both pointers advance.
  - push only: count + 1.
  - pop only: count − 1.
- Full: in_ready = 0; a simultaneous pop does not admit a push in that cycle.
- Empty: out_ready is ignored and no pointer moves. Stale head contents may remain on the out_* fields but are meaningful only while out_valid = 1.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Flush has priority over push and pop. At the edge: count = 0 and head = tail = 0; any same-cycle push or pop is discarded. Storage contents need not be cleared.
- Immediate extension:
  - ANDI, ORI, XORI: zero-extend imm[15:0].
  - LUI: {imm, 16'h0}.
  - All other opcodes: sign-extend imm[15].
- Field positions follow the standard MIPS layout:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0], addr [25:0].

Decomposition:
- cpu_types_pkg gains:
  - a decoded_t packed struct {opcode, funct, rs, rt, rd, shamt, imm_ext, addr, rtype};
  - an imm_ext_t enum {EXT_SIGN, EXT_ZERO, EXT_LUI};
  - the field boundary localparams.
  - PC remains a separate parameterised field in the FIFO entry.
- Sub-module decode_fields: purely combinational, maps word_t to decoded_t including extension-mode selection. It is reused by later stages.
- The FIFO, pointers and count logic live in decode_queue itself.

Test Plan:
- Reset then single push of in_instr=32'h2009FFFF (ADDI $t1, $zero, -1) at pc=32'h100 -> next cycle out_valid=1, out_opcode=ADDI, out_rt=9, out_imm_ext=32'hFFFFFFFF, out_pc=32'h100, count=1.
- Push ORI 32'h3409FFFF, then LUI 32'h3C091234 -> heads read out_imm_ext=32'h0000FFFF, then 32'h12340000, in order.
- Hold out_ready=0 and push three instructions with DEPTH=2 -> in_ready drops after the second push; the third is held upstream; count=2; head unchanged.
- Continuous in_valid=1 and out_ready=1 over 8 R-type instructions (e.g. 32'h012A4020 ADD $t0,$t1,$t2) -> one output per cycle, out_rtype=1, out_rd=8, out_funct=ADD, and count stays at 1.
- With count=2, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, and the pushed instruction never appears.
- Drop nRST mid-stream with count=1 -> out_valid=0 and in_ready=1 immediately (asynchronously); all out_* fields read 0 until the next push.
